// File: rtl/jam_cost_table_if.sv
// Load/read bundle for the job-assignment cost table.
// Optional COST_CHECKSUM_EN adds the running checksum output.
interface jam_cost_table_if #(
  parameter int N_WORKER = 8,
  parameter int N_JOB    = 8,
  parameter int COST_W   = 7
);
  localparam int WW = $clog2(N_WORKER);
  localparam int JW = $clog2(N_JOB);
  localparam int PW = $clog2(N_WORKER * N_JOB);

  logic              clear;
  logic              load_valid;
  logic              load_ready;
  logic [COST_W-1:0] load_data;
  logic [WW-1:0]     W;
  logic [JW-1:0]     J;
  logic [COST_W-1:0] Cost;
  logic              table_ready;
  logic              load_overrun;
`ifdef COST_CHECKSUM_EN
  logic [COST_W+PW-1:0] checksum;
`endif

  modport master (
`ifdef COST_CHECKSUM_EN
    input  checksum,
`endif
    output clear, load_valid, load_data, W, J,
    input  load_ready, Cost, table_ready, load_overrun
  );

  modport slave (
`ifdef COST_CHECKSUM_EN
    output checksum,
`endif
    input  clear, load_valid, load_data, W, J,
    output load_ready, Cost, table_ready, load_overrun
  );
endinterface

// File: rtl/jam_cost_table.sv
// Cost-matrix server: loads a row-major worker x job stream, then serves table[W][J].
// Optional feature: define COST_CHECKSUM_EN for a running sum of accepted beats.
module jam_cost_table #(
  parameter int N_WORKER = 8,
  parameter int N_JOB    = 8,
  parameter int COST_W   = 7
) (
  input logic             CLK,
  input logic             RST,
  jam_cost_table_if.slave bus
);
  localparam int JW = $clog2(N_JOB);
  localparam int PW = $clog2(N_WORKER * N_JOB);
  localparam logic [PW-1:0] LAST = PW'(N_WORKER * N_JOB - 1);

  typedef enum logic [0:0] {LOAD = 1'b0, READY = 1'b1} state_t;

  state_t            state, next_state;
  logic [PW-1:0]     ptr;
  logic              accept;
  logic              overrun;
  logic [COST_W-1:0] mem [N_WORKER][N_JOB];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= LOAD;
    else     state <= next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    unique case (state)
      LOAD: begin
        accept = bus.load_valid;
        if (accept && ptr == LAST) next_state = READY;
      end
      READY: next_state = READY;
      default: next_state = LOAD;
    endcase
    // A reload request wins over a beat arriving in the same cycle.
    if (bus.clear) begin
      next_state = LOAD;
      accept     = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           ptr <= '0;
    else if (bus.clear) ptr <= '0;
    else if (accept)   ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                   overrun <= 1'b0;
    else if (bus.clear)                        overrun <= 1'b0;
    else if (state == READY && bus.load_valid) overrun <= 1'b1;
  end

  // NOTE: the storage array has no reset; contents are only meaningful once table_ready is set.
  always_ff @(posedge CLK) begin
    if (accept) mem[ptr[PW-1:JW]][ptr[JW-1:0]] <= bus.load_data;
  end

  assign bus.load_ready   = (state == LOAD);
  assign bus.table_ready  = (state == READY);
  assign bus.load_overrun = overrun;
  assign bus.Cost         = bus.table_ready ? mem[bus.W][bus.J] : '0;

`ifdef COST_CHECKSUM_EN
  logic [COST_W+PW-1:0] sum;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            sum <= '0;
    else if (bus.clear) sum <= '0;
    else if (accept)    sum <= sum + (COST_W+PW)'(bus.load_data);
  end

  assign bus.checksum = sum;
`endif
endmodule
